// File: rtl/vec3_mul_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// vec3_mul_arbiter_pkg
// Shared types and helpers for the vec3 multiply arbiter slice.
//   fixed_t / vec3_t   : signed Q16.16 scalar and a packed {x, y, z} vector
//   req_id_width()     : width of a requester id for a given requester count
//   mul_fixed()        : fixed-point multiply, truncating toward -inf, wrapping
//   broadcast_x()      : replicate the x lane into all three lanes
// ----------------------------------------------------------------------------
package vec3_mul_arbiter_pkg;

    localparam int FIXED_WIDTH = 32;
    localparam int FRAC_BITS   = 16;
    localparam int VEC3_WIDTH  = 3 * FIXED_WIDTH;

    typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

    // x occupies the most significant lane of the packed vector
    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } vec3_t;

    // A single requester still needs a one-bit id so the tag path has a width
    function automatic int req_id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Full-precision product, then an arithmetic shift drops the extra
    // fraction bits (floor) and the cast keeps the low word (wrap, no saturate)
    function automatic fixed_t mul_fixed(input fixed_t a, input fixed_t b);
        logic signed [2*FIXED_WIDTH-1:0] prod;
        prod = a * b;
        return fixed_t'(prod >>> FRAC_BITS);
    endfunction

    function automatic vec3_t broadcast_x(input vec3_t v);
        vec3_t r;
        r.x = v.x;
        r.y = v.x;
        r.z = v.x;
        return r;
    endfunction

endpackage

// File: rtl/vec3_mul_arbiter_mul_vec3.sv
// ----------------------------------------------------------------------------
// vec3_mul_arbiter_mul_vec3
// Lane-wise fixed-point vec3 multiplier with a fixed LATENCY-deep pipeline.
//   clk_i         in  1           clock
//   rst_i         in  1           asynchronous active-high reset, flushes pipe
//   din_valid_i   in  1           operands present
//   din_a_i       in  VEC3_WIDTH  operand a
//   din_b_i       in  VEC3_WIDTH  operand b
//   dout_valid_o  out 1           result present, LATENCY cycles after input
//   dout_o        out VEC3_WIDTH  lane-wise product a*b
// ----------------------------------------------------------------------------
module vec3_mul_arbiter_mul_vec3
    import vec3_mul_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  din_valid_i,
    input  logic [VEC3_WIDTH-1:0] din_a_i,
    input  logic [VEC3_WIDTH-1:0] din_b_i,
    output logic                  dout_valid_o,
    output logic [VEC3_WIDTH-1:0] dout_o
);

    vec3_t a_vec;
    vec3_t b_vec;
    vec3_t prod;

    logic [LATENCY-1:0] valid_q;
    vec3_t              data_q [LATENCY];

    assign a_vec = din_a_i;
    assign b_vec = din_b_i;

    always_comb begin
        prod   = '0;
        prod.x = mul_fixed(a_vec.x, b_vec.x);
        prod.y = mul_fixed(a_vec.y, b_vec.y);
        prod.z = mul_fixed(a_vec.z, b_vec.z);
    end

    // Product is formed at the input and then delayed; stage 0 is the first register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= din_valid_i;
            data_q[0]  <= prod;
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign dout_valid_o = valid_q[LATENCY-1];
    assign dout_o       = data_q[LATENCY-1];

endmodule

// File: rtl/vec3_mul_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// vec3_mul_arbiter_rr_arbiter
// Combinational round-robin picker: the first eligible index found scanning
// rr_ptr, rr_ptr+1, ... (mod NUM_REQ) wins.
//   eligible_i     in  NUM_REQ  requesters allowed to issue this cycle
//   rr_ptr_i       in  ID_W     index with highest priority this cycle
//   grant_o        out NUM_REQ  one-hot grant, zero when nothing is eligible
//   grant_idx_o    out ID_W     index of the granted requester
//   grant_valid_o  out 1        a grant was made
// ----------------------------------------------------------------------------
module vec3_mul_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_valid_o
);

    int             scan_pos;
    logic [ID_W-1:0] scan_idx;
    logic           found;

    // Wrap the scan position by subtraction so non power-of-two counts work
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        found         = 1'b0;
        scan_pos      = 0;
        scan_idx      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_pos = int'(rr_ptr_i) + off;
            if (scan_pos >= NUM_REQ) begin
                scan_pos = scan_pos - NUM_REQ;
            end
            scan_idx = ID_W'(scan_pos);
            if (!found && eligible_i[scan_idx]) begin
                found              = 1'b1;
                grant_o[scan_idx]  = 1'b1;
                grant_idx_o        = scan_idx;
                grant_valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec3_mul_arbiter.sv
// ----------------------------------------------------------------------------
// vec3_mul_arbiter
// Shares one vec3 multiplier among NUM_REQ requesters. One op is granted per
// cycle round-robin, tagged with the requester id, and its result lands in
// that requester's single-entry response buffer.
//   clk_i         in  1                    clock
//   rst_ni        in  1                    asynchronous active-low reset
//   req_valid_i   in  NUM_REQ              requester i presents an op
//   req_ready_o   out NUM_REQ              op i accepted this cycle (one-hot/zero)
//   req_a_i       in  NUM_REQ*VEC3_WIDTH   operand a, requester i at slice i
//   req_b_i       in  NUM_REQ*VEC3_WIDTH   operand b, requester i at slice i
//   req_scalar_i  in  NUM_REQ              1: a * b.x on all lanes, 0: a * b
//   resp_valid_o  out NUM_REQ              result buffered for requester i
//   resp_ready_i  in  NUM_REQ              requester i consumes its result
//   resp_data_o   out NUM_REQ*VEC3_WIDTH   result for requester i
// ----------------------------------------------------------------------------
module vec3_mul_arbiter
    import vec3_mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*VEC3_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*VEC3_WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]            req_scalar_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [NUM_REQ*VEC3_WIDTH-1:0] resp_data_o
);

    localparam int ID_W = req_id_width(NUM_REQ);

    logic [NUM_REQ-1:0][VEC3_WIDTH-1:0] req_a_arr;
    logic [NUM_REQ-1:0][VEC3_WIDTH-1:0] req_b_arr;

    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;

    logic [MUL_LATENCY-1:0] tag_valid_q;
    logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];

    logic [NUM_REQ-1:0] inflight;
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;

    vec3_t              din_a;
    vec3_t              sel_b;
    vec3_t              din_b;
    logic               mul_dout_valid;
    logic [VEC3_WIDTH-1:0] mul_dout;

    logic               ret_valid;
    logic [ID_W-1:0]    ret_id;

    logic [NUM_REQ-1:0]                 resp_valid_q;
    logic [NUM_REQ-1:0]                 resp_valid_d;
    logic [NUM_REQ-1:0][VEC3_WIDTH-1:0] resp_data_q;
    logic [NUM_REQ-1:0][VEC3_WIDTH-1:0] resp_data_d;

    assign req_a_arr = req_a_i;
    assign req_b_arr = req_b_i;

    // A requester is in flight while any tag stage carries its id
    always_comb begin
        inflight = '0;
        for (int s = 0; s < MUL_LATENCY; s++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tag_valid_q[s] && (tag_id_q[s] == ID_W'(i))) begin
                    inflight[i] = 1'b1;
                end
            end
        end
    end

    // A buffer being drained this cycle does not block a new grant; gating
    // with rst_ni keeps req_ready low for the whole reset window
    assign busy     = inflight | (resp_valid_q & ~resp_ready_i);
    assign eligible = req_valid_i & ~busy & {NUM_REQ{rst_ni}};

    vec3_mul_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .eligible_i    (eligible),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign req_ready_o = grant;

    // Scalar mode replicates b.x so the multiplier stays purely lane-wise
    always_comb begin
        din_a = req_a_arr[grant_idx];
        sel_b = req_b_arr[grant_idx];
        din_b = req_scalar_i[grant_idx] ? broadcast_x(sel_b) : sel_b;
    end

    vec3_mul_arbiter_mul_vec3 #(
        .LATENCY (MUL_LATENCY)
    ) u_mul_vec3 (
        .clk_i        (clk_i),
        .rst_i        (~rst_ni),
        .din_valid_i  (grant_valid),
        .din_a_i      (din_a),
        .din_b_i      (din_b),
        .dout_valid_o (mul_dout_valid),
        .dout_o       (mul_dout)
    );

    // Pointer moves just past the winner, wrapping at the last requester
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Tag pipeline mirrors the multiplier depth so ids line up with results
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            tag_valid_q <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            tag_valid_q[0] <= grant_valid;
            tag_id_q[0]    <= grant_idx;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_id_q[s]    <= tag_id_q[s-1];
            end
        end
    end

    assign ret_valid = mul_dout_valid & tag_valid_q[MUL_LATENCY-1];
    assign ret_id    = tag_id_q[MUL_LATENCY-1];

    // Drain clears the flag but leaves the data; a return sets both
    always_comb begin
        resp_valid_d = resp_valid_q & ~resp_ready_i;
        resp_data_d  = resp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ret_valid && (ret_id == ID_W'(i))) begin
                resp_valid_d[i] = 1'b1;
                resp_data_d[i]  = mul_dout;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;

    // A result must never land on a buffer that still holds one
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(ret_valid && (ret_id == ID_W'(gi)) && resp_valid_q[gi]));
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant));

endmodule

// File: tb/tb_vec3_mul_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vec3_mul_arbiter
// Directed bench for vec3_mul_arbiter (NUM_REQ=4, MUL_LATENCY=1, Q16.16).
// Inputs change just after each falling edge; outputs are sampled 1ns later,
// so each step below describes one clock cycle.
// ----------------------------------------------------------------------------
module tb_vec3_mul_arbiter;

    logic             clk = 1'b0;
    logic             rstN;
    logic [3:0]       reqValid;
    logic [3:0]       reqReady;
    logic [3:0]       reqScalar;
    logic [3:0]       respValid;
    logic [3:0]       respReady;
    logic [3:0][95:0] reqA;
    logic [3:0][95:0] reqB;
    logic [3:0][95:0] respData;

    int compared = 0;
    int failed   = 0;

    localparam logic [31:0] Q_HALF    = 32'h0000_8000;
    localparam logic [31:0] Q_QUARTER = 32'h0000_4000;
    localparam logic [31:0] Q_1_5     = 32'h0001_8000;

    always #5 clk = ~clk;

    vec3_mul_arbiter #(
        .NUM_REQ     (4),
        .MUL_LATENCY (1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_a_i      (reqA),
        .req_b_i      (reqB),
        .req_scalar_i (reqScalar),
        .resp_valid_o (respValid),
        .resp_ready_i (respReady),
        .resp_data_o  (respData)
    );

    // Integer to Q16.16
    function automatic logic [31:0] fq(input int v);
        return 32'(v * 65536);
    endfunction

    function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return {x, y, z};
    endfunction

    // Streaming-test op n: a=(n+1, -(n+1), 0.5), b=(2, 3, n)
    function automatic logic [95:0] opA(input int n);
        return vec(fq(n + 1), fq(-(n + 1)), Q_HALF);
    endfunction

    function automatic logic [95:0] opB(input int n);
        return vec(fq(2), fq(3), fq(n));
    endfunction

    // Expected product: (2n+2, -3n-3, n/2)
    function automatic logic [95:0] opRes(input int n);
        return vec(fq(2 * n + 2), fq(-3 * n - 3), 32'(n * 32768));
    endfunction

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] scalar,
                                 input logic [3:0] ready);
        @(negedge clk);
        reqValid  = valid;
        reqScalar = scalar;
        respReady = ready;
        #1;
    endtask

    task automatic setOps(input int idx, input logic [95:0] a, input logic [95:0] b);
        reqA[idx] = a;
        reqB[idx] = b;
    endtask

    task automatic checkOutput(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN      = 1'b0;
        reqValid  = '0;
        reqScalar = '0;
        respReady = '0;
        reqA      = '0;
        reqB      = '0;

        // Reset state, with every requester asking
        applyStimulus(4'hF, 4'h0, 4'h0);
        checkOutput("reset req_ready", reqReady, 4'h0);
        checkOutput("reset resp_valid", respValid, 4'h0);
        checkOutput("reset resp_data0", respData[0], '0);
        checkOutput("reset resp_data3", respData[3], '0);
        applyStimulus(4'h0, 4'h0, 4'h0);
        rstN = 1'b1;

        // Streaming: all four valid, responses always consumed
        for (int n = 0; n < 4; n++) begin
            setOps(n, opA(n), opB(n));
        end
        for (int w = 0; w < 10; w++) begin
            applyStimulus((w < 8) ? 4'hF : 4'h0, 4'h0, 4'hF);
            if (w >= 1 && w + 3 < 8) begin
                setOps((w - 1) % 4, opA(w + 3), opB(w + 3));
            end
            checkOutput($sformatf("stream ready w%0d", w), reqReady,
                        (w < 8) ? (4'b0001 << (w % 4)) : 4'b0000);
            if (w >= 2) begin
                checkOutput($sformatf("stream valid w%0d", w), respValid,
                            4'b0001 << ((w - 2) % 4));
                checkOutput($sformatf("stream data w%0d", w), respData[(w - 2) % 4],
                            opRes(w - 2));
            end else begin
                checkOutput($sformatf("stream valid w%0d", w), respValid, 4'h0);
            end
        end
        applyStimulus(4'h0, 4'h0, 4'h0);
        checkOutput("stream idle valid", respValid, 4'h0);

        // Single element-wise op on req0
        applyStimulus(4'b0001, 4'h0, 4'h0);
        setOps(0, vec(Q_1_5, fq(2), fq(-1)), vec(fq(2), Q_HALF, fq(3)));
        checkOutput("single ready", reqReady, 4'b0001);
        applyStimulus(4'h0, 4'h0, 4'h0);
        checkOutput("single valid T+1", respValid, 4'h0);
        applyStimulus(4'h0, 4'h0, 4'b0001);
        checkOutput("single valid T+2", respValid, 4'b0001);
        checkOutput("single data", respData[0], vec(fq(3), fq(1), fq(-3)));
        applyStimulus(4'h0, 4'h0, 4'h0);
        checkOutput("single drained", respValid, 4'h0);
        checkOutput("single data held", respData[0], vec(fq(3), fq(1), fq(-3)));

        // Scalar mode on req1, b.y/b.z are junk
        applyStimulus(4'b0010, 4'b0010, 4'h0);
        setOps(1, vec(fq(1), fq(-2), fq(4)), vec(Q_QUARTER, 32'h1234_5678, 32'hDEAD_BEEF));
        checkOutput("scalar ready", reqReady, 4'b0010);
        applyStimulus(4'h0, 4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0, 4'b0010);
        checkOutput("scalar valid", respValid, 4'b0010);
        checkOutput("scalar data", respData[1], vec(Q_QUARTER, 32'hFFFF_8000, fq(1)));
        applyStimulus(4'h0, 4'h0, 4'h0);
        checkOutput("scalar drained", respValid, 4'h0);

        // Truncation toward -inf and integer wrap on req3
        applyStimulus(4'b1000, 4'h0, 4'h0);
        setOps(3, vec(32'hFFFF_FFFF, Q_1_5, 32'h7FFF_0000), vec(Q_HALF, Q_HALF, fq(2)));
        checkOutput("trunc ready", reqReady, 4'b1000);
        applyStimulus(4'h0, 4'h0, 4'h0);
        applyStimulus(4'h0, 4'h0, 4'b1000);
        checkOutput("trunc valid", respValid, 4'b1000);
        checkOutput("trunc data", respData[3], vec(32'hFFFF_FFFF, 32'h0000_C000, 32'hFFFE_0000));
        applyStimulus(4'h0, 4'h0, 4'h0);

        // Backpressure on req2
        applyStimulus(4'b0100, 4'h0, 4'h0);
        setOps(2, vec(fq(1), fq(1), fq(1)), vec(fq(5), fq(6), fq(7)));
        checkOutput("bp grant2", reqReady, 4'b0100);
        applyStimulus(4'b0101, 4'h0, 4'h0);
        setOps(2, vec(fq(2), fq(2), fq(2)), vec(fq(5), fq(6), fq(7)));
        setOps(0, vec(fq(1), fq(2), fq(3)), vec(fq(1), fq(1), fq(1)));
        checkOutput("bp inflight grant0", reqReady, 4'b0001);
        applyStimulus(4'b0110, 4'h0, 4'h0);
        setOps(1, vec(fq(-1), fq(-1), fq(-1)), vec(fq(4), fq(4), fq(4)));
        checkOutput("bp pending grant1", reqReady, 4'b0010);
        checkOutput("bp valid c", respValid, 4'b0100);
        checkOutput("bp data2 first", respData[2], vec(fq(5), fq(6), fq(7)));
        applyStimulus(4'b0100, 4'h0, 4'h0);
        checkOutput("bp blocked", reqReady, 4'h0);
        checkOutput("bp valid d", respValid, 4'b0101);
        checkOutput("bp data0", respData[0], vec(fq(1), fq(2), fq(3)));
        applyStimulus(4'b0100, 4'h0, 4'b0100);
        checkOutput("bp drain grant2", reqReady, 4'b0100);
        checkOutput("bp valid e", respValid, 4'b0111);
        checkOutput("bp data1", respData[1], vec(fq(-4), fq(-4), fq(-4)));
        applyStimulus(4'h0, 4'h0, 4'b0011);
        checkOutput("bp valid f", respValid, 4'b0011);
        checkOutput("bp data2 held", respData[2], vec(fq(5), fq(6), fq(7)));
        applyStimulus(4'h0, 4'h0, 4'b0100);
        checkOutput("bp valid g", respValid, 4'b0100);
        checkOutput("bp data2 second", respData[2], vec(fq(10), fq(12), fq(14)));
        applyStimulus(4'h0, 4'h0, 4'h0);
        checkOutput("bp idle", respValid, 4'h0);

        // Pointer wrap: rr_ptr is 3, req1 and req3 valid
        applyStimulus(4'b1010, 4'h0, 4'hF);
        checkOutput("wrap grant3", reqReady, 4'b1000);
        applyStimulus(4'b1010, 4'h0, 4'hF);
        checkOutput("wrap grant1", reqReady, 4'b0010);
        checkOutput("wrap valid none", respValid, 4'h0);
        applyStimulus(4'hF, 4'h0, 4'hF);
        checkOutput("wrap ptr2 grant", reqReady, 4'b0100);
        checkOutput("wrap valid3", respValid, 4'b1000);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkOutput("wrap valid1", respValid, 4'b0010);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkOutput("wrap valid2", respValid, 4'b0100);
        applyStimulus(4'h0, 4'h0, 4'hF);
        checkOutput("wrap idle", respValid, 4'h0);

        // Reset mid-operation: req1 result pending, req2 in flight
        applyStimulus(4'b0010, 4'h0, 4'h0);
        checkOutput("rst pre grant1", reqReady, 4'b0010);
        applyStimulus(4'b0100, 4'h0, 4'h0);
        checkOutput("rst pre grant2", reqReady, 4'b0100);
        applyStimulus(4'hF, 4'h0, 4'h0);
        checkOutput("rst pre valid", respValid, 4'b0010);
        rstN = 1'b0;
        #1;
        checkOutput("rst async valid", respValid, 4'h0);
        checkOutput("rst async ready", reqReady, 4'h0);
        checkOutput("rst async data1", respData[1], '0);
        applyStimulus(4'h0, 4'h0, 4'h0);
        rstN = 1'b1;
        checkOutput("rst release valid", respValid, 4'h0);
        applyStimulus(4'h0, 4'h0, 4'h0);
        checkOutput("rst after1 valid", respValid, 4'h0);
        applyStimulus(4'h0, 4'h0, 4'h0);
        checkOutput("rst after2 valid", respValid, 4'h0);
        applyStimulus(4'hF, 4'h0, 4'h0);
        checkOutput("rst restart grant0", reqReady, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
